// File: rtl/ifmap_window_gen.sv
// Streaming sliding-window generator: raster pixels in, stride-aligned KxK windows out.
// K-1 line buffers feed a KxK shift register; emitted windows are held in an output register.
module ifmap_window_gen #(
    parameter int unsigned IP_DATA_WIDTH = 8,
    parameter int unsigned IFMAP_SIZE    = 5,
    parameter int unsigned FILTER_SIZE   = 3,
    parameter int unsigned STRIDE        = 1,
    parameter int unsigned OFMAP_SIZE    = (IFMAP_SIZE - FILTER_SIZE) / STRIDE + 1,
    localparam int unsigned CW           = (OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE) : 1
) (
    input  logic                                                       clk,
    input  logic                                                       rst,
    input  logic                                                       in_valid,
    output logic                                                       in_ready,
    input  logic [IP_DATA_WIDTH-1:0]                                   in_data,
    output logic                                                       out_valid,
    input  logic                                                       out_ready,
    output logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][IP_DATA_WIDTH-1:0] out_window,
    output logic [CW-1:0]                                              out_row,
    output logic [CW-1:0]                                              out_col,
    output logic                                                       frame_done
);

    localparam int unsigned RW = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;
    localparam int unsigned PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [RW-1:0] PosLast  = RW'(IFMAP_SIZE - 1);
    localparam logic [RW-1:0] PosFirst = RW'(FILTER_SIZE - 1);
    localparam logic [PW-1:0] PhLast   = PW'(STRIDE - 1);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e state_q, state_d;

    logic [RW-1:0] row_q, row_d, col_q, col_d;
    // Phase: (pos-(K-1)) mod STRIDE; quotient: (pos-(K-1)) / STRIDE. Both 0 before K-1.
    logic [PW-1:0] row_ph_q, row_ph_d, col_ph_q, col_ph_d;
    logic [CW-1:0] row_qt_q, row_qt_d, col_qt_q, col_qt_d;

    logic [IP_DATA_WIDTH-1:0] lb_q [FILTER_SIZE-1][IFMAP_SIZE];
    logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][IP_DATA_WIDTH-1:0] win_q, win_d;

    logic accept, emit, row_end, frame_end;

    assign out_valid = (state_q == StFull);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign row_end   = (col_q == PosLast);
    assign frame_end = row_end && (row_q == PosLast);
    assign emit      = accept && (row_q >= PosFirst) && (col_q >= PosFirst) &&
                       (row_ph_q == '0) && (col_ph_q == '0);

    always_comb begin
        win_d = win_q;
        for (int r = 0; r < FILTER_SIZE; r++) begin
            for (int c = 0; c < FILTER_SIZE - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
        end
        for (int r = 0; r < FILTER_SIZE - 1; r++) begin
            win_d[r][FILTER_SIZE-1] = lb_q[r][col_q];
        end
        win_d[FILTER_SIZE-1][FILTER_SIZE-1] = in_data;
    end

    always_comb begin
        row_d    = row_q;
        col_d    = col_q;
        row_ph_d = row_ph_q;
        col_ph_d = col_ph_q;
        row_qt_d = row_qt_q;
        col_qt_d = col_qt_q;
        if (accept) begin
            if (row_end) begin
                col_d    = '0;
                col_ph_d = '0;
                col_qt_d = '0;
                if (row_q == PosLast) begin
                    row_d    = '0;
                    row_ph_d = '0;
                    row_qt_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                    if (row_q < PosFirst) begin
                        row_ph_d = '0;
                        row_qt_d = '0;
                    end else if (row_ph_q == PhLast) begin
                        row_ph_d = '0;
                        row_qt_d = row_qt_q + 1'b1;
                    end else begin
                        row_ph_d = row_ph_q + 1'b1;
                    end
                end
            end else begin
                col_d = col_q + 1'b1;
                if (col_q < PosFirst) begin
                    col_ph_d = '0;
                    col_qt_d = '0;
                end else if (col_ph_q == PhLast) begin
                    col_ph_d = '0;
                    col_qt_d = col_qt_q + 1'b1;
                end else begin
                    col_ph_d = col_ph_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (emit) state_d = StFull;
            StFull:  if (out_ready && !emit) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEmpty;
            row_q      <= '0;
            col_q      <= '0;
            row_ph_q   <= '0;
            col_ph_q   <= '0;
            row_qt_q   <= '0;
            col_qt_q   <= '0;
            win_q      <= '0;
            out_window <= '0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            row_ph_q   <= row_ph_d;
            col_ph_q   <= col_ph_d;
            row_qt_q   <= row_qt_d;
            col_qt_q   <= col_qt_d;
            frame_done <= accept && frame_end;
            if (accept) begin
                win_q <= win_d;
            end
            if (emit) begin
                out_window <= win_d;
                out_row    <= row_qt_q;
                out_col    <= col_qt_q;
            end
        end
    end

    // Line buffers are never cleared; emission only starts once K rows of this frame exist.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < FILTER_SIZE - 2; i++) begin
                lb_q[i][col_q] <= lb_q[i+1][col_q];
            end
            lb_q[FILTER_SIZE-2][col_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_ifmap_window_gen.sv
// Self-checking bench for ifmap_window_gen: stride-1 and stride-2 instances against a
// frame-array reference model; one instance is driven at a time.
module tb_ifmap_window_gen;

    localparam int N = 5;
    localparam int K = 3;

    typedef logic [K-1:0][K-1:0][7:0] win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic tb_valid = 1'b0;
    logic tb_ready = 1'b1;
    logic [7:0] tb_data = '0;

    logic       in_valid1, in_ready1, out_valid1, out_ready1, frame_done1;
    logic       in_valid2, in_ready2, out_valid2, out_ready2, frame_done2;
    win_t       win1, win2;
    logic [1:0] row1, col1;
    logic [0:0] row2, col2;

    logic       obs_in_ready, obs_valid, obs_done;
    win_t       obs_window;
    logic [3:0] obs_row, obs_col;

    always #5 clk = ~clk;

    assign in_valid1  = (sel == 1'b0) ? tb_valid : 1'b0;
    assign out_ready1 = (sel == 1'b0) ? tb_ready : 1'b1;
    assign in_valid2  = (sel == 1'b1) ? tb_valid : 1'b0;
    assign out_ready2 = (sel == 1'b1) ? tb_ready : 1'b1;

    assign obs_in_ready = sel ? in_ready2 : in_ready1;
    assign obs_valid    = sel ? out_valid2 : out_valid1;
    assign obs_done     = sel ? frame_done2 : frame_done1;
    assign obs_window   = sel ? win2 : win1;
    assign obs_row      = sel ? 4'(row2) : 4'(row1);
    assign obs_col      = sel ? 4'(col2) : 4'(col1);

    ifmap_window_gen #(
        .IP_DATA_WIDTH(8), .IFMAP_SIZE(N), .FILTER_SIZE(K), .STRIDE(1)
    ) u_dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(tb_data),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_window(win1), .out_row(row1),
        .out_col(col1), .frame_done(frame_done1)
    );

    ifmap_window_gen #(
        .IP_DATA_WIDTH(8), .IFMAP_SIZE(N), .FILTER_SIZE(K), .STRIDE(2)
    ) u_dut_s2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(tb_data),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_window(win2), .out_row(row2),
        .out_col(col2), .frame_done(frame_done2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: pixels of the current frame and the expected output register.
    logic [7:0] pix [N][N];
    int   mr, mc;
    logic exp_valid, exp_done;
    win_t exp_win;
    int   exp_row, exp_col;

    win_t cons_q[$];
    int   done_cnt;
    int   last_row, last_col;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic win_t mk_win(input int base);
        win_t w;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[r][c] = 8'(base + r * N + c);
        return w;
    endfunction

    task automatic model_clear();
        mr = 0; mc = 0;
        exp_valid = 1'b0; exp_done = 1'b0;
        exp_win = '0; exp_row = 0; exp_col = 0;
    endtask

    task automatic reset_dut();
        tb_valid = 1'b0; tb_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        check("rst_out_valid", 128'(obs_valid), 128'(exp_valid));
        check("rst_in_ready", 128'(obs_in_ready), 128'(1'b1));
        check("rst_window", 128'(obs_window), 128'(exp_win));
        check("rst_row", 128'(obs_row), 128'(exp_row));
        check("rst_col", 128'(obs_col), 128'(exp_col));
        check("rst_frame_done", 128'(obs_done), 128'(exp_done));
        cons_q.delete();
        done_cnt = 0;
    endtask

    // One clock cycle: drive, check the handshake, advance the model, check registered outputs.
    task automatic step(input logic v, input logic [7:0] d, input logic rdy, output bit acc);
        int s;
        bit em;
        tb_valid = v; tb_data = d; tb_ready = rdy;
        #1;
        check("in_ready", 128'(obs_in_ready), 128'(!exp_valid || rdy));
        if (obs_valid && rdy) begin
            cons_q.push_back(obs_window);
            last_row = int'(obs_row);
            last_col = int'(obs_col);
        end
        acc = v && (!exp_valid || rdy);
        s = sel ? 2 : 1;
        em = 1'b0;
        exp_done = 1'b0;
        if (acc) begin
            pix[mr][mc] = d;
            em = (mr >= K - 1) && (mc >= K - 1) &&
                 ((mr - (K - 1)) % s == 0) && ((mc - (K - 1)) % s == 0);
            if (em) begin
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        exp_win[r][c] = pix[mr - (K - 1) + r][mc - (K - 1) + c];
                exp_row = (mr - (K - 1)) / s;
                exp_col = (mc - (K - 1)) / s;
            end
            exp_done = (mr == N - 1) && (mc == N - 1);
            if (mc == N - 1) begin
                mc = 0;
                mr = (mr == N - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
        if (em) exp_valid = 1'b1;
        else if (rdy) exp_valid = 1'b0;
        @(negedge clk);
        check("out_valid", 128'(obs_valid), 128'(exp_valid));
        check("frame_done", 128'(obs_done), 128'(exp_done));
        if (obs_done) done_cnt++;
        if (exp_valid) begin
            check("out_window", 128'(obs_window), 128'(exp_win));
            check("out_row", 128'(obs_row), 128'(exp_row));
            check("out_col", 128'(obs_col), 128'(exp_col));
        end
    endtask

    task automatic send_frame(input int base, input bit rnd, input bit gaps, input bit bp,
                              input int npix);
        bit   acc, bp_done, done;
        logic v, r;
        logic [7:0] d;
        int   tries;
        bp_done = 1'b0;
        for (int p = 0; p < npix; p++) begin
            d = rnd ? 8'($urandom) : 8'(base + p);
            tries = 0;
            done = 1'b0;
            while (!done) begin
                if (bp && !bp_done && exp_valid) begin
                    for (int k = 0; k < 5; k++) begin
                        step(1'b1, d, 1'b0, acc);
                        check("bp_no_accept", 128'(acc), 128'(1'b0));
                    end
                    bp_done = 1'b1;
                end
                v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                r = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                step(v, d, r, acc);
                done = acc;
                tries++;
                if (!done && tries > 100) begin
                    check("accept_timeout", 128'(acc), 128'(1'b1));
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20 && exp_valid; i++) step(1'b0, 8'h00, 1'b1, acc);
        step(1'b0, 8'h00, 1'b1, acc);
    endtask

    task automatic check_s1_sequence(input int off, input int base);
        for (int i = 0; i < 9; i++)
            check("s1_seq", 128'(cons_q[off + i]), 128'(mk_win(base + (i / 3) * N + (i % 3))));
    endtask

    initial begin
        model_clear();
        done_cnt = 0; last_row = 0; last_col = 0;

        // Stride 1, full rate
        sel = 1'b0;
        reset_dut();
        send_frame(0, 1'b0, 1'b0, 1'b0, N * N);
        drain();
        check("s1_count", 128'(cons_q.size()), 128'(9));
        check("s1_first", 128'(cons_q[0]), 128'(mk_win(0)));
        check("s1_last", 128'(cons_q[8]), 128'(mk_win(12)));
        check("s1_last_row", 128'(last_row), 128'(2));
        check("s1_last_col", 128'(last_col), 128'(2));
        check("s1_done_cnt", 128'(done_cnt), 128'(1));
        check_s1_sequence(0, 0);

        // Backpressure: 5 stalled cycles after the first window
        reset_dut();
        send_frame(0, 1'b0, 1'b0, 1'b1, N * N);
        drain();
        check("bp_count", 128'(cons_q.size()), 128'(9));
        check_s1_sequence(0, 0);

        // Back-to-back frames
        reset_dut();
        send_frame(0, 1'b0, 1'b0, 1'b0, N * N);
        send_frame(100, 1'b0, 1'b0, 1'b0, N * N);
        drain();
        check("b2b_count", 128'(cons_q.size()), 128'(18));
        check("b2b_second_first", 128'(cons_q[9]), 128'(mk_win(100)));
        check("b2b_done_cnt", 128'(done_cnt), 128'(2));
        check_s1_sequence(9, 100);

        // Reset mid-frame after pixel 17 (a window is pending at that point)
        reset_dut();
        send_frame(0, 1'b0, 1'b0, 1'b0, 18);
        reset_dut();
        send_frame(0, 1'b0, 1'b0, 1'b0, N * N);
        drain();
        check("mid_count", 128'(cons_q.size()), 128'(9));
        check_s1_sequence(0, 0);

        // Stride 2
        sel = 1'b1;
        reset_dut();
        send_frame(0, 1'b0, 1'b0, 1'b0, N * N);
        drain();
        check("s2_count", 128'(cons_q.size()), 128'(4));
        check("s2_w00", 128'(cons_q[0]), 128'(mk_win(0)));
        check("s2_w01", 128'(cons_q[1]), 128'(mk_win(2)));
        check("s2_w10", 128'(cons_q[2]), 128'(mk_win(10)));
        check("s2_w11", 128'(cons_q[3]), 128'(mk_win(12)));
        check("s2_last_row", 128'(last_row), 128'(1));
        check("s2_last_col", 128'(last_col), 128'(1));
        check("s2_done_cnt", 128'(done_cnt), 128'(1));

        // Random gaps, random data, 3 frames per stride
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            reset_dut();
            for (int f = 0; f < 3; f++) send_frame(0, 1'b1, 1'b1, 1'b0, N * N);
            drain();
            check("rnd_count", 128'(cons_q.size()), 128'((s == 0) ? 27 : 12));
            check("rnd_done_cnt", 128'(done_cnt), 128'(3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifmap_window_gen.md
# ifmap_window_gen

Streaming sliding-window generator that sits directly upstream of `convolution`. It accepts the input feature map one pixel per handshake in raster order and buffers FILTER_SIZE-1 previous rows in line buffers. For every stride-aligned position it emits a FILTER_SIZE x FILTER_SIZE window, shaped like `convolution`'s `filter` operand, over a valid/ready interface. Each emitted window carries its output-map coordinates.

## Interface
- IP_DATA_WIDTH, from yolo_params_pkg: pixel width in bits.
- IFMAP_SIZE, from yolo_params_pkg: input map is square, IFMAP_SIZE x IFMAP_SIZE; legal range ≥ FILTER_SIZE.
- FILTER_SIZE, from yolo_params_pkg: window edge K; legal range 2..IFMAP_SIZE.
- STRIDE, from yolo_params_pkg: window step in both dimensions; legal range ≥ 1.
- OFMAP_SIZE, from yolo_params_pkg: equals (IFMAP_SIZE-FILTER_SIZE)/STRIDE+1.
- Ports:
  - clk  in  1  single clock, rising edge.
  - rst  in  1  synchronous, active-high reset.
  - in_valid  in  1  in_data is valid.
  - in_ready  out  1  block can accept a pixel.
  - in_data  in  IP_DATA_WIDTH  pixel, raster order, row 0 col 0 first.
  - out_valid  out  1  out_window holds a complete window.
  - out_ready  in  1  consumer accepts the window.
  - out_window  out  IP_DATA_WIDTH x [FILTER_SIZE][FILTER_SIZE]  [r][c]; r=0 is the top (oldest) row; c=0 is the leftmost column.
  - out_row  out  $clog2(OFMAP_SIZE) (min 1)  output-map row of the window.
  - out_col  out  $clog2(OFMAP_SIZE) (min 1)  output-map column of the window.
  - frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Accept: a pixel is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready, combinational.
- Counters: row and col track the position of the next pixel. On accept, col increments; at IFMAP_SIZE-1, col wraps to 0 and row increments. At (IFMAP_SIZE-1, IFMAP_SIZE-1), both wrap to 0 and frame_done pulses next cycle.
- Line buffers: K-1 buffers of IFMAP_SIZE entries each, indexed by col.
  - On accept, each buffer shifts down one row at address col.
  - in_data enters the newest row.
- Window register: K x K.
  - On accept, each row shifts left by one column.
  - Column K-1 loads the K-1 line-buffer values at col plus in_data; in_data goes to the bottom row.
- Emit condition, evaluated on the accepted pixel's (row, col):
  - row ≥ K-1 and col ≥ K-1;
  - (row-(K-1)) % STRIDE == 0;
  - (col-(K-1)) % STRIDE == 0.
  - Modulo is implemented with stride phase counters, not dividers.
- On emit:
  - out_window takes the post-shift window contents.
  - out_row = (row-(K-1))/STRIDE; out_col = (col-(K-1))/STRIDE.
  - out_valid is set.
- Output state: two-state FSM on out_valid.
  - EMPTY → FULL on an emitting accept.
  - FULL → EMPTY on out_ready with no emitting accept the same cycle.
  - FULL stays FULL when out_ready and an emitting accept coincide; the register reloads with the new window.
- Stability: out_window, out_row and out_col are stable while out_valid && !out_ready.
- Stale data: line buffers are not cleared between frames or on reset. Stale data can never reach an emitted window because emission requires row ≥ K-1 within the current frame.
- Arithmetic: none on pixel data; data is moved only. Coordinate widths are as declared.

## Timing
- Reset: out_valid=0, in_ready=1 (follows from out_valid=0), out_window all 0, out_row=0, out_col=0, frame_done=0.
- Reset also clears the row/col and stride-phase counters to 0.
- Latency: out_valid is asserted on the cycle after the emitting pixel is accepted.
- Throughput: one pixel per cycle while out_ready=1.
- Backpressure: when out_valid=1 and out_ready=0, in_ready=0 and no counter or buffer changes.
- Reset mid-frame: the partial frame is discarded and any pending window is dropped. The next accepted pixel is treated as (0,0).
- frame_done is registered. It asserts the cycle after the final accept, concurrent with out_valid for the last window when that pixel emits.

## Test plan
- Stride 1, full rate: IFMAP_SIZE=5, FILTER_SIZE=3, STRIDE=1, pixels 0..24, out_ready=1.
  - Expect 9 windows.
  - First window is the cycle after pixel 12 is accepted: [[0,1,2],[5,6,7],[10,11,12]], row 0, col 0.
  - Last window is [[12,13,14],[17,18,19],[22,23,24]], row 2, col 2.
  - frame_done pulses once.
- Stride 2: same frame with STRIDE=2.
  - Exactly 4 windows, emitted after pixels 12, 14, 22, 24, with coordinates (0,0), (0,1), (1,0), (1,1).
  - Window (1,1) is [[12,13,14],[17,18,19],[22,23,24]].
- Backpressure:
  - Hold out_ready=0 for 5 cycles after the first window.
  - Expect in_ready=0, window held stable, no pixel lost.
  - The total window sequence is identical to the stride-1 full-rate case.
- Back-to-back frames: two frames, second frame pixels 100..124.
  - Second frame's first window is [[100,101,102],[105,106,107],[110,111,112]]; no stale values.
  - frame_done pulses twice.
- Reset mid-frame:
  - Assert rst after pixel 17, then send a fresh frame 0..24.
  - Expect out_valid=0 the cycle after reset and outputs zeroed.
  - Then exactly the 9 stride-1 windows.
- Random in_valid/out_ready gaps (50% each, 3 frames): windows match a reference model in order and count.
